// File: rtl/ldst_exec_fsm.sv
// Execute-stage controller for LOAD/STORE: drives register file, MAR/MDR and the
// memory en/rw/mfc handshake, then pulses restart back to the fetch FSM.
module ldst_exec_fsm #(
    parameter int unsigned          TMO_W       = 8,
    parameter logic [TMO_W-1:0]     MFC_TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] start_code,
    input  logic [2:0] rs_idx,
    input  logic [2:0] rd_idx,
    input  logic       mfc,
    output logic       rf_out_en,
    output logic [2:0] rf_out_sel,
    output logic       rf_in_en,
    output logic [2:0] rf_in_sel,
    output logic [2:0] mar_mdr_we,
    output logic [2:0] mar_mdr_re,
    output logic       mem_en,
    output logic       mem_rw,
    output logic       restart,
    output logic       busy,
    output logic       err
);

    localparam logic [6:0]       CodeLoad  = 7'b0100000;
    localparam logic [6:0]       CodeStore = 7'b1000000;
    localparam logic [TMO_W-1:0] TmoLast   = MFC_TIMEOUT - TMO_W'(1);

    typedef enum logic [3:0] {
        StIdle, StLAddr, StLMar, StLReq, StLWait, StLRel, StLWb,
        StSAddr, StSMar, StSData, StSReq, StSWait, StSRel,
        StDone, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [6:0]       prev_code_q;
    logic [2:0]       rs_q, rs_d;
    logic [2:0]       rd_q, rd_d;
    logic             is_wait;
    logic             tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prev_code_q <= '0;
            rs_q        <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_code_q <= start_code;
            rs_q        <= rs_d;
            rd_q        <= rd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        rd_d       = rd_q;
        rf_out_en  = 1'b0;
        rf_out_sel = '0;
        rf_in_en   = 1'b0;
        rf_in_sel  = '0;
        mar_mdr_we = '0;
        mar_mdr_re = '0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        restart    = 1'b0;
        busy       = (state_q != StIdle) && (state_q != StErr);
        err        = 1'b0;
        is_wait    = (state_q == StLWait) || (state_q == StLRel) ||
                     (state_q == StSWait) || (state_q == StSRel);
        tmo        = is_wait && (cnt_q == TmoLast);

        unique case (state_q)
            StIdle: begin
                // Edge-detect so a code held across DONE->IDLE is not re-run.
                if (start_code != prev_code_q &&
                    (start_code == CodeLoad || start_code == CodeStore)) begin
                    rs_d    = rs_idx;
                    rd_d    = rd_idx;
                    state_d = (start_code == CodeLoad) ? StLAddr : StSAddr;
                end
            end
            StLAddr: begin
                rf_out_en  = 1'b1;
                rf_out_sel = rs_q;
                state_d    = StLMar;
            end
            StLMar: begin
                rf_out_en  = 1'b1;
                rf_out_sel = rs_q;
                mar_mdr_we = 3'b100;
                state_d    = StLReq;
            end
            StLReq: begin
                mar_mdr_re = 3'b100;
                mem_en     = 1'b1;
                mem_rw     = 1'b1;
                state_d    = StLWait;
            end
            StLWait: begin
                mar_mdr_re = 3'b100;
                mar_mdr_we = 3'b001;
                mem_en     = 1'b1;
                mem_rw     = 1'b1;
                if (mfc)      state_d = StLRel;
                else if (tmo) state_d = StErr;
            end
            StLRel: begin
                mem_rw = 1'b1;
                if (!mfc)     state_d = StLWb;
                else if (tmo) state_d = StErr;
            end
            StLWb: begin
                mar_mdr_re = 3'b010;
                rf_in_en   = 1'b1;
                rf_in_sel  = rd_q;
                state_d    = StDone;
            end
            StSAddr: begin
                rf_out_en  = 1'b1;
                rf_out_sel = rs_q;
                state_d    = StSMar;
            end
            StSMar: begin
                rf_out_en  = 1'b1;
                rf_out_sel = rs_q;
                mar_mdr_we = 3'b100;
                state_d    = StSData;
            end
            StSData: begin
                rf_out_en  = 1'b1;
                rf_out_sel = rd_q;
                mar_mdr_we = 3'b010;
                state_d    = StSReq;
            end
            StSReq: begin
                mar_mdr_re = 3'b101;
                mem_en     = 1'b1;
                state_d    = StSWait;
            end
            StSWait: begin
                mar_mdr_re = 3'b101;
                mem_en     = 1'b1;
                if (mfc)      state_d = StSRel;
                else if (tmo) state_d = StErr;
            end
            StSRel: begin
                if (!mfc)     state_d = StDone;
                else if (tmo) state_d = StErr;
            end
            StDone: begin
                restart = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                err = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Counter restarts on every state change, runs while parked in a wait state.
        cnt_d = (is_wait && state_d == state_q) ? cnt_q + TMO_W'(1) : '0;
    end

endmodule

// File: tb/tb_ldst_exec_fsm.sv
// Directed self-checking bench for ldst_exec_fsm: per-state output vectors,
// edge-detected accept, illegal codes, mfc timeout and asynchronous reset.
module tb_ldst_exec_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] start_code;
    logic [2:0] rs_idx;
    logic [2:0] rd_idx;
    logic       mfc;
    logic       rf_out_en;
    logic [2:0] rf_out_sel;
    logic       rf_in_en;
    logic [2:0] rf_in_sel;
    logic [2:0] mar_mdr_we;
    logic [2:0] mar_mdr_re;
    logic       mem_en;
    logic       mem_rw;
    logic       restart;
    logic       busy;
    logic       err;

    // {out_en, out_sel, in_en, in_sel, we, re, mem_en, mem_rw, restart, busy, err}
    logic [18:0] outs;
    assign outs = {rf_out_en, rf_out_sel, rf_in_en, rf_in_sel, mar_mdr_we, mar_mdr_re,
                   mem_en, mem_rw, restart, busy, err};

    int checks = 0;
    int errors = 0;
    logic auto_mfc = 1'b0;

    localparam logic [6:0] LOAD  = 7'b0100000;
    localparam logic [6:0] STORE = 7'b1000000;

    ldst_exec_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .start_code (start_code),
        .rs_idx     (rs_idx),
        .rd_idx     (rd_idx),
        .mfc        (mfc),
        .rf_out_en  (rf_out_en),
        .rf_out_sel (rf_out_sel),
        .rf_in_en   (rf_in_en),
        .rf_in_sel  (rf_in_sel),
        .mar_mdr_we (mar_mdr_we),
        .mar_mdr_re (mar_mdr_re),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .restart    (restart),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mfc) mfc = mem_en;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_code = '0; rs_idx = '0; rd_idx = '0; mfc = 1'b0;
        step();
        step();
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs, 19'h0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", outs, 19'h0);
        end
    endtask

    task automatic test_load();
        logic [18:0] exp_v [1:9];
        exp_v[1] = {1'b1, 3'd2, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_v[2] = {1'b1, 3'd2, 1'b0, 3'd0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_v[3] = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v[4] = {1'b0, 3'd0, 1'b0, 3'd0, 3'b001, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v[5] = exp_v[4];
        exp_v[6] = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v[7] = {1'b0, 3'd0, 1'b1, 3'd5, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_v[8] = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_v[9] = 19'h0;
        auto_mfc = 1'b0; mfc = 1'b0;
        start_code = LOAD; rs_idx = 3'd2; rd_idx = 3'd5;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n == 1) begin
                start_code = '0; rs_idx = 3'd7; rd_idx = 3'd7;
            end
            checks++;
            if (outs !== exp_v[n]) begin
                errors++;
                $display("FAIL load_cycle%0d: got %b expected %b", n, outs, exp_v[n]);
            end
            if (n == 5) mfc = 1'b1;
            if (n == 6) mfc = 1'b0;
        end
    endtask

    task automatic test_store();
        logic [18:0] exp_v;
        logic        saw_in_en;
        saw_in_en = 1'b0;
        auto_mfc = 1'b0; mfc = 1'b0;
        start_code = STORE; rs_idx = 3'd1; rd_idx = 3'd3;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 1) start_code = '0;
            case (n)
                1:  exp_v = {1'b1, 3'd1, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                2:  exp_v = {1'b1, 3'd1, 1'b0, 3'd0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                3:  exp_v = {1'b1, 3'd3, 1'b0, 3'd0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                4, 5, 6, 7, 8:
                    exp_v = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
                9:  exp_v = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                10: exp_v = {1'b0, 3'd0, 1'b0, 3'd0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
                default: exp_v = 19'h0;
            endcase
            if (rf_in_en) saw_in_en = 1'b1;
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL store_cycle%0d: got %b expected %b", n, outs, exp_v);
            end
            if (n == 8) mfc = 1'b1;
            if (n == 9) mfc = 1'b0;
        end
        checks++;
        if (saw_in_en !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rf_in: got %b expected 0", saw_in_en);
        end
    endtask

    // Fast memory: mfc follows mem_en, so each WAIT state lasts one cycle.
    task automatic test_latency(input logic [6:0] code);
        int restart_at;
        restart_at = -1;
        auto_mfc = 1'b1; mfc = 1'b0;
        start_code = code; rs_idx = 3'd4; rd_idx = 3'd6;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 1) start_code = '0;
            if (restart === 1'b1 && restart_at < 0) restart_at = n;
        end
        checks++;
        if (restart_at !== 7) begin
            errors++;
            $display("FAIL latency_%b: restart at cycle %0d expected 7", code, restart_at);
        end
        auto_mfc = 1'b0;
    endtask

    task automatic test_held_code();
        int pulses;
        pulses = 0;
        auto_mfc = 1'b1; mfc = 1'b0;
        start_code = LOAD; rs_idx = 3'd1; rd_idx = 3'd2;
        for (int n = 0; n < 20; n++) begin
            step();
            if (restart === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_code: pulses %0d busy %b expected 1 and 0", pulses, busy);
        end
        start_code = '0;
        step();
        start_code = LOAD;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (restart === 1'b1) pulses++;
        end
        start_code = '0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL held_code_rearm: pulses %0d expected 1", pulses);
        end
        auto_mfc = 1'b0;
    endtask

    task automatic test_illegal();
        logic [6:0] codes [2];
        codes[0] = 7'b0000001;
        codes[1] = 7'b1111111;
        for (int i = 0; i < 2; i++) begin
            start_code = codes[i];
            step();
            step();
            checks++;
            if (outs !== 19'h0) begin
                errors++;
                $display("FAIL illegal_%b: got %b expected %b", codes[i], outs, 19'h0);
            end
            start_code = '0;
            step();
        end
    endtask

    task automatic test_timeout();
        logic saw_restart;
        saw_restart = 1'b0;
        auto_mfc = 1'b0; mfc = 1'b0;
        start_code = LOAD; rs_idx = 3'd3; rd_idx = 3'd3;
        // L_WAIT entered at cycle 4; 200 cycles there, ERR from cycle 204.
        for (int n = 1; n <= 203; n++) begin
            step();
            if (n == 1) start_code = '0;
            if (restart === 1'b1) saw_restart = 1'b1;
        end
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pre: busy %b err %b mem_en %b expected 1 0 1",
                     busy, err, mem_en);
        end
        step();
        checks++;
        if (outs !== 19'h1) begin
            errors++;
            $display("FAIL timeout_err: got %b expected %b", outs, 19'h1);
        end
        start_code = LOAD;
        for (int n = 0; n < 10; n++) begin
            step();
            if (restart === 1'b1) saw_restart = 1'b1;
        end
        start_code = '0;
        checks++;
        if (outs !== 19'h1 || saw_restart !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got %b restart_seen %b expected %b 0",
                     outs, saw_restart, 19'h1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL timeout_rst_clear: got %b expected %b", outs, 19'h0);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        auto_mfc = 1'b0; mfc = 1'b0;
        start_code = LOAD; rs_idx = 3'd5; rd_idx = 3'd1;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 1) start_code = '0;
        end
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_wait: mem_en %b expected 1", mem_en);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL async_rst_outs: got %b expected %b", outs, 19'h0);
        end
        #1;
        rst = 1'b0;
        step();
        auto_mfc = 1'b1;
        start_code = LOAD; rs_idx = 3'd4; rd_idx = 3'd6;
        for (int n = 1; n <= 7; n++) begin
            step();
            if (n == 1) start_code = '0;
            if (n == 6) begin
                checks++;
                if (rf_in_en !== 1'b1 || rf_in_sel !== 3'd6) begin
                    errors++;
                    $display("FAIL async_after_wb: in_en %b in_sel %0d expected 1 6",
                             rf_in_en, rf_in_sel);
                end
            end
        end
        checks++;
        if (restart !== 1'b1) begin
            errors++;
            $display("FAIL async_after_restart: got %b expected 1", restart);
        end
        auto_mfc = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_latency(LOAD);
        test_latency(STORE);
        test_held_code();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldst_exec_fsm.md
Name: ldst_exec_fsm

Overview:
- Execute-stage controller for LOAD and STORE. Sits directly downstream of the fetch/decode FSM and consumes its 7-bit one-hot next-FSM code.
- Sequences the register file, MAR/MDR and memory handshake (en/rw/mfc) to complete one memory-access instruction.
- Pulses restart back to the fetch FSM so the next fetch begins.

Parameters:
- TMO_W, 8, width of the mfc timeout counter.
- MFC_TIMEOUT, 8'd200, number of cycles spent in a wait state before declaring a bus error.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_code  in  7  next-FSM code from fetch; 7'b0100000 = LOAD, 7'b1000000 = STORE; all other values are ignored
- rs_idx  in  3  address register index, captured at accept
- rd_idx  in  3  data register index (LOAD destination / STORE source), captured at accept
- mfc  in  1  memory function complete
- rf_out_en  out  1  register file drives bus
- rf_out_sel  out  3  register driving bus
- rf_in_en  out  1  register file loads from bus
- rf_in_sel  out  3  register loaded
- mar_mdr_we  out  3  write enables: [2] MAR<-bus, [1] MDR<-bus, [0] MDR<-mem
- mar_mdr_re  out  3  read enables: [2] MAR->mem, [1] MDR->bus, [0] MDR->mem
- mem_en  out  1  memory request
- mem_rw  out  1  1 = read, 0 = write
- restart  out  1  one-cycle pulse to fetch FSM on completion
- busy  out  1  high in every state except IDLE and ERR
- err  out  1  sticky mfc-timeout flag

Behaviour:
- Moore machine: every output is a function of the current state register only. Any output not listed for a state is 0.
- rst (async) forces IDLE: state=IDLE, timeout counter=0, prev_code=0, captured indices=0. All outputs are then 0.
- prev_code is a register that samples start_code every cycle.
- Accept rule: in IDLE, a start is accepted when start_code equals LOAD or STORE and prev_code != start_code (rising-edge detect). A code held high across DONE->IDLE is never re-accepted.
- At accept, rs_idx, rd_idx and the operation are captured. Inputs are ignored in every other state.

LOAD sequence:
- L_ADDR: rf_out_en=1, rf_out_sel=rs.
- L_MAR: rf_out_en=1, rf_out_sel=rs, we=100.
- L_REQ: re=100, mem_en=1, mem_rw=1.
- L_WAIT: re=100, we=001, mem_en=1, mem_rw=1. Stay while mfc=0; go to L_REL on mfc=1.
- L_REL: mem_rw=1 only. Stay while mfc=1; go to L_WB on mfc=0.
- L_WB: re=010, rf_in_en=1, rf_in_sel=rd.
- DONE.

STORE sequence:
- S_ADDR: rf_out_en=1, rf_out_sel=rs.
- S_MAR: rf_out_en=1, rf_out_sel=rs, we=100.
- S_DATA: rf_out_en=1, rf_out_sel=rd, we=010.
- S_REQ: re=101, mem_en=1, mem_rw=0.
- S_WAIT: re=101, mem_en=1, mem_rw=0. Go to S_REL on mfc=1.
- S_REL: all outputs 0. Go to DONE on mfc=0.

Common states:
- DONE: restart=1 for exactly one cycle, then unconditionally IDLE.
- Timeout: the counter clears on entry to each WAIT/REL state and increments each cycle spent there. When the count reaches MFC_TIMEOUT-1 and the exit condition is still unmet, the next state is ERR.
- ERR: all outputs 0 except err=1. restart is never pulsed. ERR is left only by rst.
- Latency, LOAD with mfc high on the first L_WAIT cycle and low the next: accept edge at cycle 0, restart high at cycle 7. STORE in the same case: restart high at cycle 7.
- mfc already high on entry to L_WAIT: L_WAIT lasts exactly one cycle.
- start_code changes mid-operation: no effect.
- rst mid-operation: outputs drop to 0 asynchronously with no restart pulse. Memory-side recovery is the memory's responsibility.

Test Plan:
- LOAD: rst, then start_code 0->7'b0100000, rs=2, rd=5, mfc high 1 cycle after L_WAIT entry, low 1 cycle later -> rf_out_sel=2 with we=100; mem_en/mem_rw=1/1; rf_in_en=1 with rf_in_sel=5, re=010; restart single pulse at cycle 8; busy low afterward.
- STORE: start_code=7'b1000000, rs=1, rd=3, mfc responds after 4 cycles -> S_DATA drives rf_out_sel=3, we=010; re=101 with mem_rw=0 for the full wait; one restart pulse; no rf_in_en ever asserted.
- Held code: start_code kept at LOAD for 20 cycles -> exactly one operation and one restart pulse; after dropping to 0 and rising again, a second operation runs.
- Illegal codes: start_code=7'b0000001 and 7'b1111111 -> stays IDLE, all outputs 0, busy=0.
- Timeout: LOAD with mfc stuck at 0 -> after MFC_TIMEOUT cycles in L_WAIT, err=1 and all other outputs 0; err persists; no restart; rst clears err.
- Async reset: rst asserted mid-L_WAIT, between clock edges -> mem_en and all outputs 0 immediately; following LOAD edge completes normally.
